// File: rtl/ps_pwm_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : ps_pwm_cfg_loader
// Purpose  : Serialises a parallel PS-PWM configuration word onto the
//            CLK_SR / Data_SR shift-register port of the PWM core, LSB first.
//            Every bit gets a setup, high and hold phase of DIV cycles each.
// Ports    : CLK      - system clock, rising edge
//            RST      - asynchronous active-low reset
//            cfg_word - configuration word, captured on an accepted start
//            start    - load request, accepted only while idle
//            abort    - cancel an in-progress load (ignored when idle)
//            busy     - load in progress
//            done     - one-cycle pulse on successful completion
//            CLK_SR   - shift clock to the PWM core
//            Data_SR  - serial data to the PWM core
// Revision : 1.0 - initial release
// ============================================================================
module ps_pwm_cfg_loader #(
  parameter int N_BITS = 18,
  parameter int DIV    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_BITS-1:0] cfg_word,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              CLK_SR,
  output logic              Data_SR
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [PW-1:0]     phase;
  logic [BW-1:0]     bit_idx;
  logic [N_BITS-1:0] shreg;
  logic [N_BITS-1:0] shifted;
  logic              phase_end;

  assign shifted   = shreg >> 1;
  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      phase   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      CLK_SR  <= 1'b0;
      Data_SR <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        // Abort overrides everything else, including a concurrent start.
        state   <= IDLE;
        phase   <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
        CLK_SR  <= 1'b0;
        Data_SR <= 1'b0;
      end else begin
        // The phase counter free-runs through the active states and wraps
        // at the end of each phase.
        if (state != IDLE) begin
          phase <= phase_end ? '0 : phase + 1'b1;
        end
        case (state)
          IDLE: begin
            if (start) begin
              shreg   <= cfg_word;
              bit_idx <= '0;
              phase   <= '0;
              busy    <= 1'b1;
              CLK_SR  <= 1'b0;
              Data_SR <= cfg_word[0];
              state   <= SETUP;
            end
          end
          SETUP: begin
            if (phase_end) begin
              CLK_SR <= 1'b1;
              state  <= HIGH;
            end
          end
          HIGH: begin
            if (phase_end) begin
              CLK_SR <= 1'b0;
              state  <= HOLD;
            end
          end
          HOLD: begin
            if (phase_end) begin
              if (bit_idx == BIT_LAST) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                Data_SR <= 1'b0;
                state   <= IDLE;
              end else begin
                // Data only moves here, after CLK_SR has been low for a
                // full hold phase.
                shreg   <= shifted;
                Data_SR <= shifted[0];
                bit_idx <= bit_idx + 1'b1;
                state   <= SETUP;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps_pwm_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_pwm_cfg_loader
// Purpose  : Self-checking bench for ps_pwm_cfg_loader. Instance A uses the
//            default DIV=4, instance B uses DIV=1. Expected serial bits are
//            queued when a load is started and compared at each CLK_SR rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_pwm_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, abort_a;
  logic [17:0] cfg_a;
  logic        busy_a, done_a, clk_sr_a, data_sr_a;
  logic        start_b, abort_b;
  logic [17:0] cfg_b;
  logic        busy_b, done_b, clk_sr_b, data_sr_b;

  ps_pwm_cfg_loader #(.N_BITS(18), .DIV(4)) u_dut_a (
    .CLK(clk), .RST(rst_n), .cfg_word(cfg_a), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .CLK_SR(clk_sr_a), .Data_SR(data_sr_a)
  );

  ps_pwm_cfg_loader #(.N_BITS(18), .DIV(1)) u_dut_b (
    .CLK(clk), .RST(rst_n), .cfg_word(cfg_b), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .CLK_SR(clk_sr_b), .Data_SR(data_sr_b)
  );

  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  int   rises_a = 0, done_cnt_a = 0, rises_b = 0, done_cnt_b = 0;
  int   r0, d0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic exp_bit;
  logic q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One cycle: advance to the next falling edge and run the monitors.
  task automatic tick();
    @(negedge clk);
    t++;
    if (clk_sr_a && !prev_a) begin
      rises_a++;
      chk("rise_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_bit = q.pop_front();
        chk("bit_at_rise", 32'(data_sr_a), 32'(exp_bit));
      end
    end
    prev_a = clk_sr_a;
    if (done_a) done_cnt_a++;
    if (busy_b) chk("b_data_one", 32'(data_sr_b), 1);
    if (clk_sr_b && !prev_b) rises_b++;
    prev_b = clk_sr_b;
    if (done_b) done_cnt_b++;
  endtask

  task automatic go_to(input int k);
    while (t < k) tick();
  endtask

  task automatic push_word(input logic [17:0] w);
    for (int i = 0; i < 18; i++) q.push_back(w[i]);
  endtask

  // Pulse start for one cycle; afterwards t=1 is the first busy cycle.
  task automatic load_a(input logic [17:0] w);
    cfg_a   = w;
    start_a = 1'b1;
    t       = 0;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    // ---------------- reset held with start high ----------------
    rst_n = 1'b0; start_a = 1'b1; abort_a = 1'b0; cfg_a = 18'h3FFFF;
    start_b = 1'b1; abort_b = 1'b0; cfg_b = 18'h3FFFF;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_clk_sr", 32'(clk_sr_a), 0);
    chk("rst_data_sr", 32'(data_sr_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    start_a = 1'b0; start_b = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_clk_sr", 32'(clk_sr_a), 0);

    // ---------------- nominal load, DIV=4 ----------------
    push_word(18'h28103);
    r0 = rises_a; d0 = done_cnt_a;
    load_a(18'h28103);
    chk("c1_busy", 32'(busy_a), 1);
    chk("c1_clk_sr", 32'(clk_sr_a), 0);
    chk("c1_data_sr", 32'(data_sr_a), 1);
    go_to(4);   chk("c4_clk_low", 32'(clk_sr_a), 0);
    go_to(5);   chk("c5_clk_high", 32'(clk_sr_a), 1);
    go_to(9);   chk("c9_clk_low", 32'(clk_sr_a), 0);
    go_to(216); chk("c216_busy", 32'(busy_a), 1);
                chk("c216_done", 32'(done_a), 0);
    go_to(217); chk("c217_done", 32'(done_a), 1);
                chk("c217_busy", 32'(busy_a), 0);
                chk("c217_data", 32'(data_sr_a), 0);
    go_to(218); chk("c218_done", 32'(done_a), 0);
    chk("nom_rises", 32'(rises_a - r0), 18);
    chk("nom_q_empty", 32'(q.size()), 0);
    chk("nom_done_cnt", 32'(done_cnt_a - d0), 1);

    // ---------------- DIV=1, all ones ----------------
    start_b = 1'b1; t = 0; tick(); start_b = 1'b0;
    go_to(2);  chk("b_c2_clk_high", 32'(clk_sr_b), 1);
    go_to(3);  chk("b_c3_clk_low", 32'(clk_sr_b), 0);
    go_to(54); chk("b_c54_busy", 32'(busy_b), 1);
               chk("b_c54_done", 32'(done_b), 0);
    go_to(55); chk("b_c55_done", 32'(done_b), 1);
               chk("b_c55_busy", 32'(busy_b), 0);
    chk("b_rises", 32'(rises_b), 18);
    chk("b_done_cnt", 32'(done_cnt_b), 1);

    // ---------------- start while busy ----------------
    push_word(18'h2A5C3);
    d0 = done_cnt_a;
    load_a(18'h2A5C3);
    go_to(50);
    cfg_a = 18'h15A3C; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    go_to(217); chk("sb_done", 32'(done_a), 1);
    go_to(260);
    chk("sb_done_cnt", 32'(done_cnt_a - d0), 1);
    chk("sb_busy", 32'(busy_a), 0);
    chk("sb_q_empty", 32'(q.size()), 0);

    // ---------------- abort in HIGH of bit 5 ----------------
    push_word(18'h3C0F5);
    d0 = done_cnt_a;
    load_a(18'h3C0F5);
    go_to(65); chk("ab_high_bit5", 32'(clk_sr_a), 1);
    go_to(66);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("ab_busy", 32'(busy_a), 0);
    chk("ab_clk_sr", 32'(clk_sr_a), 0);
    chk("ab_data_sr", 32'(data_sr_a), 0);
    chk("ab_bits_left", 32'(q.size()), 12);
    q.delete();
    repeat (20) tick();
    chk("ab_no_done", 32'(done_cnt_a - d0), 0);
    chk("ab_idle", 32'(busy_a), 0);
    push_word(18'h3C0F5);
    load_a(18'h3C0F5);
    chk("ab_reload_bit0", 32'(data_sr_a), 1);
    go_to(217); chk("ab_reload_done", 32'(done_a), 1);
    go_to(218);
    chk("ab_reload_q", 32'(q.size()), 0);
    chk("ab_reload_cnt", 32'(done_cnt_a - d0), 1);

    // ---------------- back-to-back, then reset mid-load ----------------
    push_word(18'h1B2D6);
    push_word(18'h1B2D6);
    d0 = done_cnt_a;
    cfg_a = 18'h1B2D6; start_a = 1'b1; t = 0;
    tick();
    chk("bb_c1_busy", 32'(busy_a), 1);
    go_to(217); chk("bb_done", 32'(done_a), 1);
                chk("bb_done_busy", 32'(busy_a), 0);
    go_to(218); chk("bb_restart_busy", 32'(busy_a), 1);
                chk("bb_restart_bit0", 32'(data_sr_a), 0);
    start_a = 1'b0;
    go_to(340); chk("rm_busy_before", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy_a), 0);
    chk("rm_done", 32'(done_a), 0);
    chk("rm_clk_sr", 32'(clk_sr_a), 0);
    chk("rm_data_sr", 32'(data_sr_a), 0);
    chk("rm_bits_left", 32'(q.size()), 8);
    q.delete();
    tick();
    rst_n = 1'b1;
    repeat (250) tick();
    chk("rm_no_done", 32'(done_cnt_a - d0), 1);
    chk("rm_idle", 32'(busy_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps_pwm_cfg_loader.md
# ps_pwm_cfg_loader

Sequencer that serialises the PS-PWM configuration word into the `CLK_SR`/`Data_SR` shift-register port of the PWM core. A host or register bank supplies a parallel word and a `start` strobe. The block emits bit 0 first, with programmable setup, high and hold phases. It reports `busy` and a one-cycle `done` pulse, and can be cancelled with `abort`. It sits between the system controller and the PWM core and replaces hand-toggled configuration writes.

## Interface
Parameters:
- `N_BITS`, default 18: configuration bits per load. Default map:
  - [4:0] dt
  - [6:5] SELECTOR_SIGNAL_GENERATOR_1
  - [8:7] SELECTOR_SIGNAL_GENERATOR_2
  - [12:9] OUTPUT_SELECTOR_EXTERNAL
  - [13] INPUT_SELECTOR
  - [14] CLK_SELECTOR
  - [15] PS_SELECTOR
  - [16] PS3_SELECTOR
  - [17] ENABLE_OUTPUT
- `DIV`, default 4: CLK cycles per phase (setup, high, hold). Must be ≥1.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `cfg_word`  in  N_BITS  configuration word; sampled only on an accepted start.
- `start`  in  1  load request; accepted when `busy`=0.
- `abort`  in  1  cancel the load in progress; ignored when idle.
- `busy`  out  1  high from the cycle after acceptance until the load completes or aborts.
- `done`  out  1  one-cycle pulse on successful completion.
- `CLK_SR`  out  1  shift clock to the PWM core.
- `Data_SR`  out  1  serial data to the PWM core.

## Operation
- All outputs are registered. Reset values: `busy`=0, `done`=0, `CLK_SR`=0, `Data_SR`=0, state IDLE, counters 0.
- States: IDLE, SETUP, HIGH, HOLD.
- **IDLE**
  - If `start`=1, capture `cfg_word` into the shift register, set bit index 0, go to SETUP.
  - `abort` is ignored in IDLE.
- **SETUP** (DIV cycles)
  - `Data_SR` = current bit; `CLK_SR`=0.
  - Go to HIGH when the phase counter reaches DIV-1.
- **HIGH** (DIV cycles)
  - `CLK_SR`=1; `Data_SR` stable.
  - Then go to HOLD.
- **HOLD** (DIV cycles)
  - `CLK_SR`=0; `Data_SR` still stable.
  - At the end of the phase:
    - If bit index = N_BITS-1, go to IDLE, pulse `done`, and drive `Data_SR`=0.
    - Otherwise shift right, increment the bit index, and go to SETUP.
- **abort**
  - Any of SETUP, HIGH or HOLD goes to IDLE on the next edge.
  - `CLK_SR`=0, `Data_SR`=0, `busy`=0, no `done` pulse.
  - The PWM core is left partially loaded; the host must reload it.
- **abort and start in the same cycle while busy:** abort wins. The start is not accepted.
- **start while busy:** ignored and not queued.
- **Counter widths:** phase counter `$clog2(DIV)` bits (minimum 1); bit index `$clog2(N_BITS)` bits (minimum 1). No wrap past N_BITS-1.
- **`RST` asserted mid-load:** all outputs go to reset values immediately (asynchronously). The load is lost.

## Timing
- Cycle 0: `start` sampled high with `busy`=0.
- Cycle 1: `busy`=1, `CLK_SR`=0, `Data_SR`=cfg_word[0].
- For bit k, relative to cycle 1:
  - `CLK_SR` rises at cycle 1 + 3·DIV·k + DIV.
  - `CLK_SR` falls DIV cycles later.
  - `Data_SR` changes only at phase boundaries where `CLK_SR` has been low for at least DIV cycles.
- Completion: `done`=1 and `busy`=0 in cycle 1 + 3·DIV·N_BITS. With defaults this is cycle 217.
- `start` in the `done` cycle is accepted, giving back-to-back loads with no gap cycle beyond the IDLE cycle.
- `abort` latency: 1 cycle to IDLE outputs.

## Test plan
- **Reset:** hold `RST`=0 with `start`=1 → `busy`, `done`, `CLK_SR`, `Data_SR` all 0. Release → still IDLE until `start`.
- **Nominal load:** DIV=4, cfg_word=18'h28103, pulse `start`.
  - Exactly 18 `CLK_SR` rising edges.
  - Bits sampled at each rise are 1,1,0,0,0,0,0,0,1,0,0,0,0,0,0,1,0,1.
  - `done` pulse at cycle 217; `busy` high for cycles 1–216.
- **DIV=1, cfg_word=all ones:** `CLK_SR` high 1 cycle per bit; `done` at cycle 55; `Data_SR`=1 throughout SETUP/HIGH/HOLD.
- **start while busy:** second `start` at cycle 50 with a different word → ignored. Serial stream matches the first word only; a single `done` pulse.
- **Abort:** abort in HIGH of bit 5.
  - Next cycle: `busy`=0, `CLK_SR`=0, `Data_SR`=0; no `done`.
  - A new `start` then loads the full word from bit 0.
- **Back-to-back and reset mid-load:**
  - `start` held high → second load begins in the `done` cycle.
  - `RST` pulsed low during bit 10 → outputs reset immediately, and no `done` pulse occurs.
